// File: rtl/scoot_step_sequencer_if.sv
// Move handshake between the step sequencer and the arena model.
// The sequencer offers a direction; the arena accepts it with move_ready.
interface scoot_step_sequencer_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/scoot_step_sequencer.sv
// Drives one combinational scootbot brain through sense/settle/decide/move steps,
// resolving its four direction outputs into a single move per step.
module scoot_step_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STEP_LIMIT    = 200,
  parameter int STALL_LIMIT   = 16,
  parameter int STEP_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [4:0]                 sensor_in,
  output logic [4:0]                 bot_in,
  input  logic [3:0]                 bot_out,
  scoot_step_sequencer_if.master     move_bus,
  output logic                       busy,
  output logic                       done,
  output logic                       stuck,
  output logic [STEP_W-1:0]          step_count
);

  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_DECIDE = 3'd3,
    S_ISSUE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_r;
  logic [SET_W-1:0]    settle_r;
  logic [STALL_W-1:0]  stall_r;
  logic                axis_horz_r;
  logic                move_valid_r;
  logic [1:0]          move_dir_r;
  logic [4:0]          bot_in_r;
  logic                busy_r;
  logic                done_r;
  logic                stuck_r;
  logic [STEP_W-1:0]   step_r;

  logic [3:0]          res_s;
  logic                vert_s;
  logic                horz_s;
  logic                stall_s;
  logic                diag_s;
  logic [1:0]          dir_s;
  logic [STEP_W-1:0]   step_next_s;
  logic [STALL_W-1:0]  stall_next_s;

  assign move_bus.move_valid = move_valid_r;
  assign move_bus.move_dir   = move_dir_r;
  assign bot_in              = bot_in_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign stuck               = stuck_r;
  assign step_count          = step_r;

  assign step_next_s  = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
  assign stall_next_s = stall_r + {{(STALL_W-1){1'b0}}, 1'b1};

  // Cancel opposing pairs, then pick the single move (axis pointer breaks diagonals).
  always_comb begin
    res_s = bot_out;
    if (bot_out[0] && bot_out[2]) begin
      res_s[0] = 1'b0;
      res_s[2] = 1'b0;
    end else begin
      res_s[0] = bot_out[0];
      res_s[2] = bot_out[2];
    end
    if (bot_out[1] && bot_out[3]) begin
      res_s[1] = 1'b0;
      res_s[3] = 1'b0;
    end else begin
      res_s[1] = bot_out[1];
      res_s[3] = bot_out[3];
    end
    vert_s  = res_s[0] | res_s[2];
    horz_s  = res_s[1] | res_s[3];
    stall_s = !vert_s && !horz_s;
    diag_s  = vert_s && horz_s;
    dir_s   = 2'd0;
    if (diag_s && axis_horz_r) begin
      dir_s = res_s[1] ? 2'd1 : 2'd3;
    end else if (vert_s) begin
      dir_s = res_s[0] ? 2'd0 : 2'd2;
    end else begin
      dir_s = res_s[1] ? 2'd1 : 2'd3;
    end
  end

  // Step FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      settle_r     <= {SET_W{1'b0}};
      stall_r      <= {STALL_W{1'b0}};
      axis_horz_r  <= 1'b0;
      move_valid_r <= 1'b0;
      move_dir_r   <= 2'd0;
      bot_in_r     <= 5'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      stuck_r      <= 1'b0;
      step_r       <= {STEP_W{1'b0}};
    end else if (abort) begin
      // Abort wins over any same-cycle handshake, so that move is never counted.
      state_r      <= S_IDLE;
      move_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r     <= S_SAMPLE;
            step_r      <= {STEP_W{1'b0}};
            stall_r     <= {STALL_W{1'b0}};
            stuck_r     <= 1'b0;
            axis_horz_r <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        S_SAMPLE: begin
          bot_in_r <= sensor_in;
          settle_r <= SET_W'(SETTLE_CYCLES - 1);
          state_r  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_r == {SET_W{1'b0}}) begin
            state_r <= S_DECIDE;
          end else begin
            settle_r <= settle_r - {{(SET_W-1){1'b0}}, 1'b1};
          end
        end
        S_DECIDE: begin
          if (stall_s) begin
            step_r  <= step_next_s;
            stall_r <= stall_next_s;
            if (stall_next_s == STALL_W'(STALL_LIMIT)) begin
              state_r <= S_DONE;
              stuck_r <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else if (step_next_s == STEP_W'(STEP_LIMIT)) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_SAMPLE;
            end
          end else begin
            move_dir_r   <= dir_s;
            move_valid_r <= 1'b1;
            state_r      <= S_ISSUE;
            if (diag_s) begin
              axis_horz_r <= !axis_horz_r;
            end else begin
              axis_horz_r <= axis_horz_r;
            end
          end
        end
        S_ISSUE: begin
          if (move_bus.move_ready) begin
            move_valid_r <= 1'b0;
            step_r       <= step_next_s;
            stall_r      <= {STALL_W{1'b0}};
            if (step_next_s == STEP_W'(STEP_LIMIT)) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_SAMPLE;
            end
          end else begin
            state_r <= S_ISSUE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          move_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scoot_step_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// direction-resolution reference model, on a default instance and a short-run instance.
module tb_scoot_step_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] sensor_in;
  logic [3:0] bot_out;
  logic       start_a, abort_a, start_b, abort_b;
  logic [4:0] bot_in_a, bot_in_b;
  logic       busy_a, done_a, stuck_a, busy_b, done_b, stuck_b;
  logic [7:0] step_a;
  logic [3:0] step_b;

  scoot_step_sequencer_if mif_a ();
  scoot_step_sequencer_if mif_b ();

  scoot_step_sequencer #(.SETTLE_CYCLES(4), .STEP_LIMIT(200), .STALL_LIMIT(16), .STEP_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .sensor_in(sensor_in),
    .bot_in(bot_in_a), .bot_out(bot_out), .move_bus(mif_a), .busy(busy_a), .done(done_a),
    .stuck(stuck_a), .step_count(step_a));

  scoot_step_sequencer #(.SETTLE_CYCLES(2), .STEP_LIMIT(5), .STALL_LIMIT(3), .STEP_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .sensor_in(sensor_in),
    .bot_in(bot_in_b), .bot_out(bot_out), .move_bus(mif_b), .busy(busy_b), .done(done_b),
    .stuck(stuck_b), .step_count(step_b));

  int checks = 0;
  int errors = 0;

  // Reference resolution: cancel opposite pairs, count survivors, alternate diagonals.
  function automatic void ref_resolve(input logic [3:0] b, input bit axis_h,
                                      output bit stall, output logic [1:0] dir,
                                      output bit axis_h_next);
    bit up, rt, dn, lf;
    int n;
    up = b[0] && !b[2];
    dn = b[2] && !b[0];
    rt = b[1] && !b[3];
    lf = b[3] && !b[1];
    n = int'(up) + int'(rt) + int'(dn) + int'(lf);
    stall = (n == 0);
    axis_h_next = axis_h;
    dir = 2'd0;
    if (n == 1) dir = up ? 2'd0 : rt ? 2'd1 : dn ? 2'd2 : 2'd3;
    else if (n == 2) begin
      dir = axis_h ? (rt ? 2'd1 : 2'd3) : (up ? 2'd0 : 2'd2);
      axis_h_next = !axis_h;
    end
  endfunction

  task automatic go_idle_a();
    abort_a = 1'b1; start_a = 1'b0; mif_a.move_ready = 1'b0;
    @(posedge clk); #1;
    abort_a = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bot_in_a, mif_a.move_valid, mif_a.move_dir, busy_a, done_a, stuck_a, step_a} !== 19'd0) begin
      errors++; $display("FAIL reset_a: got %b want all zero",
        {bot_in_a, mif_a.move_valid, mif_a.move_dir, busy_a, done_a, stuck_a, step_a});
    end
    checks++;
    if ({bot_in_b, mif_b.move_valid, mif_b.move_dir, busy_b, done_b, stuck_b, step_b} !== 15'd0) begin
      errors++; $display("FAIL reset_b: got %b want all zero",
        {bot_in_b, mif_b.move_valid, mif_b.move_dir, busy_b, done_b, stuck_b, step_b});
    end
  endtask

  task automatic test_latency();
    int lat, per;
    logic [4:0] snap;
    go_idle_a();
    bot_out = 4'b0001; mif_a.move_ready = 1'b1;
    snap = 5'($urandom_range(1, 31)); sensor_in = snap;
    start_a = 1'b1; lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1; start_a = 1'b0; lat++;
      if (mif_a.move_valid) break;
    end
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL latency: got %0d cycles want 7", lat); end
    checks++;
    if (mif_a.move_dir !== 2'd0 || bot_in_a !== snap) begin
      errors++; $display("FAIL latency_dir: dir %0d bot_in %b want 0 %b", mif_a.move_dir, bot_in_a, snap);
    end
    for (int p = 0; p < 2; p++) begin
      per = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1; per++;
        if (mif_a.move_valid) break;
      end
      checks++;
      if (per !== 7 || step_a !== 8'(p + 1)) begin
        errors++; $display("FAIL period: got %0d cycles step %0d want 7 step %0d", per, step_a, p + 1);
      end
    end
  endtask

  task automatic test_diagonal();
    logic [1:0] exp_seq [4];
    int k;
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd3; exp_seq[2] = 2'd0; exp_seq[3] = 2'd3;
    go_idle_a();
    bot_out = 4'b1001; mif_a.move_ready = 1'b1;
    pulse_start_a();
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      if (mif_a.move_valid) begin
        checks++;
        if (mif_a.move_dir !== exp_seq[k]) begin
          errors++; $display("FAIL diagonal_%0d: got %0d want %0d", k, mif_a.move_dir, exp_seq[k]);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL diagonal_count: got %0d moves want 4", k); end
  endtask

  task automatic test_stall();
    bit saw_valid;
    go_idle_a();
    bot_out = 4'b0101; saw_valid = 1'b0;
    pulse_start_a();
    for (int i = 0; i < 200 && !done_a; i++) begin
      if (mif_a.move_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_valid !== 1'b0 || done_a !== 1'b1 || stuck_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL stall: valid_seen %b done %b stuck %b busy %b want 0 1 1 0",
                         saw_valid, done_a, stuck_a, busy_a);
    end
    checks++;
    if (step_a !== 8'd16) begin errors++; $display("FAIL stall_steps: got %0d want 16", step_a); end
  endtask

  task automatic test_backpressure();
    bit stable;
    logic [4:0] snap;
    go_idle_a();
    bot_out = 4'b0010; snap = 5'b01011; sensor_in = snap;
    pulse_start_a();
    for (int i = 0; i < 30 && !mif_a.move_valid; i++) begin @(posedge clk); #1; end
    stable = mif_a.move_valid;
    for (int i = 0; i < 10; i++) begin
      sensor_in = 5'($urandom);
      @(posedge clk); #1;
      if (!mif_a.move_valid || mif_a.move_dir !== 2'd1 || step_a !== 8'd0 || bot_in_a !== snap) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL backpressure_hold: got 0 want 1 (valid/dir/bot_in held)"); end
    mif_a.move_ready = 1'b1;
    @(posedge clk); #1;
    mif_a.move_ready = 1'b0;
    checks++;
    if (step_a !== 8'd1 || mif_a.move_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_accept: step %0d valid %b want 1 0", step_a, mif_a.move_valid);
    end
    repeat (12) begin @(posedge clk); #1; end
    checks++;
    if (step_a !== 8'd1) begin errors++; $display("FAIL backpressure_once: step %0d want 1", step_a); end
  endtask

  task automatic test_step_limit();
    int hs;
    bot_out = 4'b0010; mif_b.move_ready = 1'b1; hs = 0;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    for (int i = 0; i < 200 && !done_b; i++) begin
      if (mif_b.move_valid) hs++;
      @(posedge clk); #1;
    end
    checks++;
    if (hs !== 5 || step_b !== 4'd5 || stuck_b !== 1'b0 || done_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL step_limit: hs %0d step %0d stuck %b done %b busy %b want 5 5 0 1 0",
                         hs, step_b, stuck_b, done_b, busy_b);
    end
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    checks++;
    if (step_b !== 4'd0 || busy_b !== 1'b1 || done_b !== 1'b0) begin
      errors++; $display("FAIL restart: step %0d busy %b done %b want 0 1 0", step_b, busy_b, done_b);
    end
    bot_out = 4'b1111;
    for (int i = 0; i < 100 && !done_b; i++) begin @(posedge clk); #1; end
    checks++;
    if (step_b !== 4'd3 || stuck_b !== 1'b1 || done_b !== 1'b1) begin
      errors++; $display("FAIL short_stuck: step %0d stuck %b done %b want 3 1 1", step_b, stuck_b, done_b);
    end
  endtask

  task automatic test_abort();
    int n;
    go_idle_a();
    bot_out = 4'b1000; mif_a.move_ready = 1'b1; n = 0;
    pulse_start_a();
    for (int i = 0; i < 60 && n < 2; i++) begin
      if (mif_a.move_valid) n++;
      @(posedge clk); #1;
    end
    mif_a.move_ready = 1'b0;
    for (int i = 0; i < 30 && !mif_a.move_valid; i++) begin @(posedge clk); #1; end
    abort_a = 1'b1; mif_a.move_ready = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0; mif_a.move_ready = 1'b0;
    checks++;
    if (step_a !== 8'd2 || mif_a.move_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL abort: step %0d valid %b busy %b done %b want 2 0 0 0",
                         step_a, mif_a.move_valid, busy_a, done_a);
    end
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL start_abort: busy %b want 0", busy_a); end
  endtask

  task automatic test_random();
    bit axis_h, axis_n, stall, ok;
    logic [1:0] dir;
    logic [3:0] b;
    logic [4:0] snap;
    int exp_steps, exp_stall, d;
    go_idle_a();
    axis_h = 1'b0; exp_steps = 0; exp_stall = 0;
    for (int s = 0; s < 40; s++) begin
      b = 4'($urandom);
      ref_resolve(b, axis_h, stall, dir, axis_n);
      bot_out = b; snap = 5'($urandom); sensor_in = snap;
      if (s == 0) pulse_start_a();
      ok = 1'b0;
      if (!stall) begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (mif_a.move_valid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || mif_a.move_dir !== dir || bot_in_a !== snap) begin
          errors++; $display("FAIL rand_move_%0d: valid %b dir %0d bot_in %b want 1 %0d %b (bot_out %b)",
                             s, ok, mif_a.move_dir, bot_in_a, dir, snap, b);
        end
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin @(posedge clk); #1; end
        checks++;
        if (mif_a.move_valid !== 1'b1 || mif_a.move_dir !== dir) begin
          errors++; $display("FAIL rand_hold_%0d: valid %b dir %0d want 1 %0d", s, mif_a.move_valid, mif_a.move_dir, dir);
        end
        mif_a.move_ready = 1'b1;
        @(posedge clk); #1;
        mif_a.move_ready = 1'b0;
        exp_steps++; exp_stall = 0; axis_h = axis_n;
      end else begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (mif_a.move_valid) break;
          if (step_a != 8'(exp_steps)) begin ok = 1'b1; break; end
        end
        exp_steps++; exp_stall++;
        checks++;
        if (!ok || mif_a.move_valid !== 1'b0) begin
          errors++; $display("FAIL rand_stall_%0d: stepped %b valid %b want 1 0", s, ok, mif_a.move_valid);
        end
      end
      checks++;
      if (step_a !== 8'(exp_steps) || (done_a && busy_a)) begin
        errors++; $display("FAIL rand_count_%0d: got %0d want %0d (done %b busy %b)", s, step_a, exp_steps, done_a, busy_a);
      end
      if (exp_stall == 16) break;
    end
  endtask

  task automatic test_reset_mid_settle();
    go_idle_a();
    bot_out = 4'b0001; sensor_in = 5'b10110;
    pulse_start_a();
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bot_in_a !== 5'b10110 || busy_a !== 1'b1) begin
      errors++; $display("FAIL settle_pre: bot_in %b busy %b want 10110 1", bot_in_a, busy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bot_in_a, mif_a.move_valid, mif_a.move_dir, busy_a, done_a, stuck_a, step_a} !== 19'd0) begin
      errors++; $display("FAIL reset_mid_settle: got %b want all zero",
        {bot_in_a, mif_a.move_valid, mif_a.move_dir, busy_a, done_a, stuck_a, step_a});
    end
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sensor_in = 5'd0; bot_out = 4'd0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    mif_a.move_ready = 1'b0; mif_b.move_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_latency();
    test_diagonal();
    test_stall();
    test_backpressure();
    test_step_limit();
    test_abort();
    test_random();
    test_reset_mid_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
